// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Used by instr_fetch_unit and fetch_fifo.
package fetch_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JALR   = 2'b10,
        PC_RSVD   = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } fetch_state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer with flush, occupancy count and full/empty.
// Pop and push on a full buffer in the same cycle are both honoured.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, prefetches into a buffer, squashes on redirect.
// Build option FETCH_MISALIGN_TRAP_EN traps misaligned redirect targets.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    output logic        fetch_fault
);
    localparam int          CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(FIFO_DEPTH);

    fetch_state_e  state, state_next;
    pcsrc_e        pcsrc;
    logic [31:0]   fetch_pc, head_pc;
    logic [31:0]   raw_target, target, fifo_rdata;
    logic [CW-1:0] outstanding, out_next;
    logic [CW-1:0] discard, disc_next, fifo_count;
    logic [CW:0]   occupancy;
    logic          fifo_full, fifo_empty;
    logic          req_hs, consume, redirect, fault;
    logic          drop_rsp, push;

    assign pcsrc          = pcsrc_e'(PCSrc);
    assign occupancy      = {1'b0, outstanding} + {1'b0, fifo_count};
    assign imem_req_valid = (state == RUN) && (occupancy < LIMIT);
    assign imem_addr      = fetch_pc;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign instr_valid    = (state == RUN) && !fifo_empty;
    assign Instr          = instr_valid ? fifo_rdata : '0;
    assign PC             = head_pc;
    assign PCPlus4        = head_pc + 32'd4;
    assign consume        = instr_valid && instr_ready;
    assign redirect       = consume &&
                            (pcsrc == PC_BRANCH || pcsrc == PC_JALR);

    always_comb begin
        raw_target = head_pc + 32'd4;
        unique case (1'b1)
            pcsrc == PC_BRANCH: raw_target = head_pc + ImmExt;
            pcsrc == PC_JALR:   raw_target = ALUResult & ~32'h1;
            default: ;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;

    assign fault       = redirect && (raw_target[1:0] != 2'b00);
    assign target      = raw_target;
    assign fetch_fault = fault_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            fault_q <= 1'b0;
        end else if (fault) begin
            fault_q <= 1'b1;
        end
    end
`else
    assign fault       = 1'b0;
    assign target      = word_align(raw_target);
    assign fetch_fault = 1'b0;
`endif

    // Responses owed to squashed requests are counted in discard and dropped.
    assign drop_rsp = imem_rsp_valid && (discard != '0);
    assign push     = imem_rsp_valid && !drop_rsp && !redirect &&
                      (state == RUN) && (!fifo_full || consume);
    assign out_next = outstanding + CW'(req_hs) - CW'(imem_rsp_valid);

    always_comb begin
        disc_next = discard;
        if (redirect) begin
            disc_next = out_next;
        end else if (drop_rsp) begin
            disc_next = discard - CW'(1);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push),
        .pop     (consume),
        .flush   (redirect),
        .wdata   (imem_rdata),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            BOOT:    state_next = RUN;
            RUN:     if (fault) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            outstanding <= '0;
            discard     <= '0;
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
        end else begin
            outstanding <= out_next;
            discard     <= disc_next;
            if (redirect) begin
                fetch_pc <= target;
                head_pc  <= target;
            end else begin
                if (req_hs) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (consume) begin
                    head_pc <= head_pc + 32'd4;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit against a program-flow reference model.
// Honours FETCH_MISALIGN_TRAP_EN for the misaligned-target scenario.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] ImmExt = '0;
    logic [31:0] ALUResult = '0;
    logic        fetch_fault;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .Instr          (Instr),
        .PC             (PC),
        .PCPlus4        (PCPlus4),
        .PCSrc          (PCSrc),
        .ImmExt         (ImmExt),
        .ALUResult      (ALUResult),
        .fetch_fault    (fetch_fault)
    );

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int lat = 1;
    int rr_mode = 1;
    int ir_mode = 0;
    bit rand_br = 0;

    logic [31:0] q_addr[$];
    int          q_due[$];

    logic [31:0] m_pc;
    logic [31:0] exp_fetch;
    bit          m_halt;
    logic [31:0] obs_pc[$];
    logic [31:0] obs_ins[$];
    logic [31:0] exp_pc[$];
    logic [31:0] obs_addr[$];
    logic [31:0] exp_addr[$];
    int          hold_err;
    int          halt_err;
    int          max_out;
    bit          stall_pend;
    logic [31:0] stall_addr;

    bit          plan_on;
    logic [31:0] plan_pc;
    logic [1:0]  plan_src;
    logic [31:0] plan_imm;
    logic [31:0] plan_alu;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic int stream_errs();
        int e = 0;
        if (obs_pc.size() != exp_pc.size()) e++;
        if (obs_addr.size() != exp_addr.size()) e++;
        for (int i = 0; i < obs_pc.size() && i < exp_pc.size(); i++) begin
            if (obs_pc[i] !== exp_pc[i]) e++;
            if (obs_ins[i] !== mem_word(exp_pc[i])) e++;
        end
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            if (obs_addr[i] !== exp_addr[i]) e++;
        end
        return e;
    endfunction

    function automatic bit seen_pc(input logic [31:0] p);
        foreach (obs_pc[i]) if (obs_pc[i] === p) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        int v;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rdata     = mem_word(q_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rdata     = $urandom;
        end
        imem_req_ready = (rr_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        case (ir_mode)
            0:       instr_ready = 1'b0;
            1:       instr_ready = 1'b1;
            default: instr_ready = 1'($urandom_range(0, 1));
        endcase
        PCSrc     = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
        ImmExt    = $urandom;
        ALUResult = $urandom;
        if (plan_on && instr_valid && PC === plan_pc) begin
            PCSrc     = plan_src;
            ImmExt    = plan_imm;
            ALUResult = plan_alu;
        end else if (rand_br && instr_valid && $urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 1) begin
                v      = $urandom_range(0, 255);
                PCSrc  = 2'b01;
                ImmExt = 32'((v - 128) * 4);
            end else begin
                PCSrc     = 2'b10;
                ALUResult = 32'($urandom_range(0, 4095)) * 32'd4 +
                            32'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic tick();
        bit          hs, rsp, cons, redir;
        logic [31:0] t, a;
        #2;
        hs   = imem_req_valid && imem_req_ready;
        rsp  = imem_rsp_valid;
        cons = instr_valid && instr_ready;
        a    = imem_addr;
        t    = '0;
        if (stall_pend && imem_req_valid && imem_addr !== stall_addr)
            hold_err++;
        if (m_halt && (imem_req_valid || instr_valid))
            halt_err++;
        redir = cons && (PCSrc == 2'b01 || PCSrc == 2'b10);
        if (cons) begin
            obs_pc.push_back(PC);
            obs_ins.push_back(Instr);
            exp_pc.push_back(m_pc);
            if (plan_on && PC === plan_pc) plan_on = 0;
            if (redir) begin
                t = (PCSrc == 2'b01) ? m_pc + ImmExt : ALUResult & ~32'h1;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (t[1:0] != 2'b00) m_halt = 1;
`else
                t = t & ~32'h3;
`endif
                m_pc = t;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        if (hs) begin
            obs_addr.push_back(a);
            exp_addr.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redir) exp_fetch = t;
        stall_pend = imem_req_valid && !imem_req_ready && !redir;
        stall_addr = a;
        @(posedge clk);
        cyc++;
        if (rsp && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (hs) begin
            q_addr.push_back(a);
            q_due.push_back(cyc + lat - 1);
        end
        if (q_addr.size() > max_out) max_out = q_addr.size();
        #1;
        drive();
    endtask

    task automatic do_reset();
        n_reset        = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        PCSrc          = 2'b00;
        q_addr.delete();
        q_due.delete();
        obs_pc.delete();
        obs_ins.delete();
        exp_pc.delete();
        obs_addr.delete();
        exp_addr.delete();
        m_pc       = RESET_PC;
        exp_fetch  = RESET_PC;
        m_halt     = 0;
        hold_err   = 0;
        halt_err   = 0;
        max_out    = 0;
        stall_pend = 0;
        plan_on    = 0;
        rand_br    = 0;
        repeat (2) @(posedge clk);
        #1;
        n_reset = 1'b1;
        cyc     = 0;
        drive();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if ({imem_req_valid, instr_valid, fetch_fault, Instr} !== '0) begin
            n_errors++;
            $display("FAIL rst_zero_outs got %b/%b/%b/%h want 0",
                     imem_req_valid, instr_valid, fetch_fault, Instr);
        end
        n_checks++;
        if (imem_addr !== RESET_PC || PC !== RESET_PC) begin
            n_errors++;
            $display("FAIL rst_pc got addr=%h pc=%h want %h",
                     imem_addr, PC, RESET_PC);
        end
        n_checks++;
        if (PCPlus4 !== RESET_PC + 32'd4) begin
            n_errors++;
            $display("FAIL rst_pcplus4 got %h want %h", PCPlus4, RESET_PC + 4);
        end
        rr_mode = 1; ir_mode = 0; lat = 1;
        do_reset();
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL boot_no_req got %b want 0", imem_req_valid);
        end
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC) begin
            n_errors++;
            $display("FAIL run_first_req got v=%b a=%h want 1/%h",
                     imem_req_valid, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_fill();
        rr_mode = 1; ir_mode = 0; lat = 1;
        do_reset();
        repeat (10) tick();
        n_checks++;
        if (obs_addr.size() != 4 || stream_errs() != 0) begin
            n_errors++;
            $display("FAIL fill_reqs got n=%0d errs=%0d want 4/0",
                     obs_addr.size(), stream_errs());
        end
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL fill_stop got %b want 0", imem_req_valid);
        end
        n_checks++;
        if (instr_valid !== 1'b1 || PC !== 32'h0 || Instr !== mem_word(0)) begin
            n_errors++;
            $display("FAIL fill_head got v=%b pc=%h i=%h want 1/0/%h",
                     instr_valid, PC, Instr, mem_word(0));
        end
    endtask

    task automatic test_stream();
        int c0;
        rr_mode = 1; ir_mode = 1; lat = 1;
        do_reset();
        repeat (8) tick();
        c0 = obs_pc.size();
        repeat (10) tick();
        n_checks++;
        if (obs_pc.size() - c0 != 10) begin
            n_errors++;
            $display("FAIL stream_rate got %0d want 10", obs_pc.size() - c0);
        end
        rr_mode = 0;
        repeat (60) tick();
        n_checks++;
        if (stream_errs() != 0 || hold_err != 0 || obs_pc.size() < 25) begin
            n_errors++;
            $display("FAIL stream_toggle got errs=%0d hold=%0d n=%0d want 0/0/>=25",
                     stream_errs(), hold_err, obs_pc.size());
        end
    endtask

    task automatic test_branch();
        rr_mode = 1; ir_mode = 1; lat = 1;
        do_reset();
        plan_on = 1; plan_pc = 32'h8; plan_src = 2'b01;
        plan_imm = 32'h100; plan_alu = '0;
        for (int i = 0; i < 100 && obs_pc.size() < 6; i++) tick();
        n_checks++;
        if (obs_pc.size() < 6) begin
            n_errors++;
            $display("FAIL branch_timeout got %0d want 6", obs_pc.size());
        end else begin
            n_checks++;
            if (obs_pc[3] !== 32'h108) begin
                n_errors++;
                $display("FAIL branch_target got %h want 108", obs_pc[3]);
            end
        end
        n_checks++;
        if (seen_pc(32'hC) || seen_pc(32'h10) || seen_pc(32'h14) ||
            stream_errs() != 0) begin
            n_errors++;
            $display("FAIL branch_squash got errs=%0d want 0", stream_errs());
        end
    endtask

    task automatic test_jalr();
        for (int k = 0; k < 2; k++) begin
            rr_mode = 1; ir_mode = 1; lat = (k == 0) ? 1 : 3;
            do_reset();
            plan_on = 1; plan_pc = 32'h10; plan_src = 2'b10;
            plan_imm = '0; plan_alu = 32'h2001;
            for (int i = 0; i < 200 && obs_pc.size() < 8; i++) tick();
            n_checks++;
            if (obs_pc.size() < 8) begin
                n_errors++;
                $display("FAIL jalr_timeout lat=%0d got %0d want 8",
                         lat, obs_pc.size());
            end else begin
                n_checks++;
                if (obs_pc[5] !== 32'h2000 || obs_pc[7] !== 32'h2008) begin
                    n_errors++;
                    $display("FAIL jalr_target lat=%0d got %h/%h want 2000/2008",
                             lat, obs_pc[5], obs_pc[7]);
                end
            end
            n_checks++;
            if (stream_errs() != 0 || max_out > DEPTH) begin
                n_errors++;
                $display("FAIL jalr_stream lat=%0d got errs=%0d out=%0d",
                         lat, stream_errs(), max_out);
            end
        end
    endtask

    task automatic test_backpressure();
        int n0;
        rr_mode = 1; ir_mode = 1; lat = 1;
        do_reset();
        repeat (12) tick();
        ir_mode = 0;
        repeat (10) tick();
        n_checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL bp_hold got req=%b iv=%b want 0/1",
                     imem_req_valid, instr_valid);
        end
        n0 = obs_pc.size();
        ir_mode = 1;
        instr_ready = 1'b1;
        repeat (12) tick();
        n_checks++;
        if (stream_errs() != 0 || obs_pc.size() < n0 + 10) begin
            n_errors++;
            $display("FAIL bp_release got errs=%0d n=%0d want 0/>=%0d",
                     stream_errs(), obs_pc.size(), n0 + 10);
        end
        n_reset = 1'b0;
        #1;
        n_checks++;
        if ({imem_req_valid, instr_valid, fetch_fault, Instr} !== '0 ||
            imem_addr !== RESET_PC || PC !== RESET_PC ||
            PCPlus4 !== RESET_PC + 32'd4) begin
            n_errors++;
            $display("FAIL midrst got rv=%b iv=%b a=%h pc=%h want reset values",
                     imem_req_valid, instr_valid, imem_addr, PC);
        end
    endtask

    task automatic test_misalign();
        rr_mode = 1; ir_mode = 1; lat = 1;
        do_reset();
        plan_on = 1; plan_pc = 32'h0; plan_src = 2'b01;
        plan_imm = 32'h102; plan_alu = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (15) tick();
        n_checks++;
        if (fetch_fault !== 1'b1 || halt_err != 0 || obs_pc.size() != 1) begin
            n_errors++;
            $display("FAIL trap_halt got f=%b herr=%0d n=%0d want 1/0/1",
                     fetch_fault, halt_err, obs_pc.size());
        end
        n_checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL trap_quiet got rv=%b iv=%b want 0/0",
                     imem_req_valid, instr_valid);
        end
        do_reset();
        repeat (6) tick();
        n_checks++;
        if (fetch_fault !== 1'b0 || instr_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL trap_clear got f=%b iv=%b want 0/1",
                     fetch_fault, instr_valid);
        end
`else
        for (int i = 0; i < 100 && obs_pc.size() < 3; i++) tick();
        n_checks++;
        if (obs_pc.size() < 3) begin
            n_errors++;
            $display("FAIL align_timeout got %0d want 3", obs_pc.size());
        end else begin
            n_checks++;
            if (obs_pc[1] !== 32'h100) begin
                n_errors++;
                $display("FAIL align_target got %h want 100", obs_pc[1]);
            end
        end
        n_checks++;
        if (fetch_fault !== 1'b0 || stream_errs() != 0) begin
            n_errors++;
            $display("FAIL align_stream got f=%b errs=%0d want 0/0",
                     fetch_fault, stream_errs());
        end
`endif
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            rr_mode = 0; ir_mode = 2; lat = 1 + k;
            do_reset();
            rand_br = 1;
            repeat (150) tick();
            n_checks++;
            if (stream_errs() != 0 || hold_err != 0 ||
                max_out > DEPTH || obs_pc.size() < 10) begin
                n_errors++;
                $display("FAIL random lat=%0d got errs=%0d hold=%0d out=%0d n=%0d",
                         lat, stream_errs(), hold_err, max_out, obs_pc.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_branch();
        test_jalr();
        test_backpressure();
        test_misalign();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
